axis_spm_scan_gen: RTL and testbench

// - Raster scan vector generator: source of the relative scan coordinates Xs/Ys (rotation-frame, centred on scan origin) consumed by the SPM control/DAC stage.
// - Produces forward/return line pairs with per-point dwell timing, line stepping, pause/abort, saturating arithmetic.
// - Emits pixel strobes and counters for the data acquisition path.

---
 rtl/spm_ctrl_pkg.sv | 19 +
 rtl/spm_sat_add.sv | 35 +++
 rtl/axis_spm_scan_gen.sv | 197 +++++++++++++++++++
 tb/tb_axis_spm_scan_gen.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_ctrl_pkg.sv
// Shared definitions for the SPM scan generator: FSM state codes and the
// symmetric Q31 saturation limits applied to the scan coordinates.
package spm_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] LOAD  = 3'd1;
    localparam logic [STATE_W-1:0] FWD   = 3'd2;
    localparam logic [STATE_W-1:0] RET   = 3'd3;
    localparam logic [STATE_W-1:0] YSTEP = 3'd4;
    localparam logic [STATE_W-1:0] DONE  = 3'd5;

    // Symmetric range: the most negative code is never produced, so
    // negating a coordinate downstream can never overflow.
    localparam logic signed [31:0] SAT_POS = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] SAT_NEG = -32'sh7FFF_FFFF;

endpackage

// File: rtl/spm_sat_add.sv
// Signed saturating add/subtract. The operation is carried out one bit wider
// than the operands so the true result is known before clamping.
module spm_sat_add
    import spm_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                sub,
    output logic signed [W-1:0] y
);

    localparam logic signed [W:0] POS_LIM = (W+1)'(SAT_POS);
    localparam logic signed [W:0] NEG_LIM = (W+1)'(SAT_NEG);

    logic signed [W:0] a_ext;
    logic signed [W:0] b_ext;
    logic signed [W:0] sum;

    // Widen, add or subtract, then clamp into the symmetric range.
    always_comb begin
        a_ext = {a[W-1], a};
        b_ext = {b[W-1], b};
        sum   = sub ? (a_ext - b_ext) : (a_ext + b_ext);
        if (sum > POS_LIM) begin
            y = POS_LIM[W-1:0];
        end else if (sum < NEG_LIM) begin
            y = NEG_LIM[W-1:0];
        end else begin
            y = sum[W-1:0];
        end
    end

endmodule

// File: rtl/axis_spm_scan_gen.sv
// Raster scan vector generator. Produces forward/return line pairs of
// relative Xs/Ys coordinates with per-point dwell, line stepping,
// pause/abort and saturating position arithmetic.
module axis_spm_scan_gen
    import spm_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int DECI_WIDTH = 16
) (
    input  logic                         a_clk,
    input  logic                         a_resetn,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         pause,
    input  logic [CNT_WIDTH-1:0]         nx,
    input  logic [CNT_WIDTH-1:0]         ny,
    input  logic [DECI_WIDTH-1:0]        dwell,
    input  logic signed [DATA_WIDTH-1:0] x_start,
    input  logic signed [DATA_WIDTH-1:0] y_start,
    input  logic signed [DATA_WIDTH-1:0] dx,
    input  logic signed [DATA_WIDTH-1:0] dy,
    output logic signed [DATA_WIDTH-1:0] M_AXIS_Xs_tdata,
    output logic                         M_AXIS_Xs_tvalid,
    output logic signed [DATA_WIDTH-1:0] M_AXIS_Ys_tdata,
    output logic                         M_AXIS_Ys_tvalid,
    output logic                         pixel_strobe,
    output logic                         dir,
    output logic [CNT_WIDTH-1:0]         point_cnt,
    output logic [CNT_WIDTH-1:0]         line_cnt,
    output logic                         busy,
    output logic                         done
);

    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [DECI_WIDTH-1:0] DWELL_ONE = DECI_WIDTH'(1);

    logic [STATE_W-1:0]           state_reg, state_next;
    logic [CNT_WIDTH-1:0]         nx_reg, ny_reg;
    logic [DECI_WIDTH-1:0]        dwell_reg, dwell_cnt_reg;
    logic signed [DATA_WIDTH-1:0] xs_reg, dx_reg, dy_reg;
    logic signed [DATA_WIDTH-1:0] x_reg, y_reg;
    logic [CNT_WIDTH-1:0]         point_reg, line_reg;
    logic                         dir_reg, tvalid_reg;

    logic dwell_last, point_last, point_first, line_last, advance;

    // Axis adders: index 0 is X (subtracts on the return line), 1 is Y.
    logic signed [DATA_WIDTH-1:0] add_a [2];
    logic signed [DATA_WIDTH-1:0] add_b [2];
    logic signed [DATA_WIDTH-1:0] add_y [2];
    logic                         add_sub [2];

    assign add_a[0]   = x_reg;
    assign add_b[0]   = dx_reg;
    assign add_sub[0] = (state_reg == RET);
    assign add_a[1]   = y_reg;
    assign add_b[1]   = dy_reg;
    assign add_sub[1] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            spm_sat_add #(.W(DATA_WIDTH)) u_add (
                .a   (add_a[gi]),
                .b   (add_b[gi]),
                .sub (add_sub[gi]),
                .y   (add_y[gi])
            );
        end
    endgenerate

    assign dwell_last  = (dwell_cnt_reg == (dwell_reg - DWELL_ONE));
    assign point_last  = (point_reg == (nx_reg - CNT_ONE));
    assign point_first = (point_reg == '0);
    assign line_last   = (line_reg == (ny_reg - CNT_ONE));
    // Any forward progress this cycle: stop aborts, pause freezes.
    assign advance     = !stop && !pause;

    // State register.
    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; stop dominates pause and start.
    always_comb begin
        state_next = state_reg;
        if (stop) begin
            state_next = IDLE;
        end else if (!pause) begin
            case (state_reg)
                IDLE:    if (start) state_next = LOAD;
                LOAD:    state_next = FWD;
                FWD:     if (dwell_last && point_last) state_next = RET;
                RET:     if (dwell_last && point_first) state_next = line_last ? DONE : YSTEP;
                YSTEP:   if (dwell_last) state_next = FWD;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output decode from the registered state.
    always_comb begin
        busy         = (state_reg != IDLE);
        done         = (state_reg == DONE) && advance;
        pixel_strobe = advance && dwell_last && ((state_reg == FWD) || (state_reg == RET));
    end

    // Parameter latch, position, counters and dwell timing.
    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            nx_reg        <= CNT_ONE;
            ny_reg        <= CNT_ONE;
            dwell_reg     <= DWELL_ONE;
            xs_reg        <= '0;
            dx_reg        <= '0;
            dy_reg        <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            point_reg     <= '0;
            line_reg      <= '0;
            dwell_cnt_reg <= '0;
            dir_reg       <= 1'b0;
            tvalid_reg    <= 1'b0;
        end else if (advance) begin
            case (state_reg)
                LOAD: begin
                    nx_reg        <= (nx == '0) ? CNT_ONE : nx;
                    ny_reg        <= (ny == '0) ? CNT_ONE : ny;
                    dwell_reg     <= (dwell == '0) ? DWELL_ONE : dwell;
                    xs_reg        <= x_start;
                    dx_reg        <= dx;
                    dy_reg        <= dy;
                    x_reg         <= x_start;
                    y_reg         <= y_start;
                    point_reg     <= '0;
                    line_reg      <= '0;
                    dwell_cnt_reg <= '0;
                    dir_reg       <= 1'b0;
                    tvalid_reg    <= 1'b1;
                end
                FWD: begin
                    if (dwell_last) begin
                        dwell_cnt_reg <= '0;
                        if (point_last) begin
                            dir_reg <= 1'b1;
                        end else begin
                            x_reg     <= add_y[0];
                            point_reg <= point_reg + CNT_ONE;
                        end
                    end else begin
                        dwell_cnt_reg <= dwell_cnt_reg + DWELL_ONE;
                    end
                end
                RET: begin
                    if (dwell_last) begin
                        dwell_cnt_reg <= '0;
                        if (!point_first) begin
                            x_reg     <= add_y[0];
                            point_reg <= point_reg - CNT_ONE;
                        end
                    end else begin
                        dwell_cnt_reg <= dwell_cnt_reg + DWELL_ONE;
                    end
                end
                YSTEP: begin
                    if (dwell_last) begin
                        // Every forward line restarts from the latched origin.
                        dwell_cnt_reg <= '0;
                        y_reg         <= add_y[1];
                        x_reg         <= xs_reg;
                        line_reg      <= line_reg + CNT_ONE;
                        point_reg     <= '0;
                        dir_reg       <= 1'b0;
                    end else begin
                        dwell_cnt_reg <= dwell_cnt_reg + DWELL_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign M_AXIS_Xs_tdata  = x_reg;
    assign M_AXIS_Ys_tdata  = y_reg;
    assign M_AXIS_Xs_tvalid = tvalid_reg;
    assign M_AXIS_Ys_tvalid = tvalid_reg;
    assign dir              = dir_reg;
    assign point_cnt        = point_reg;
    assign line_cnt         = line_reg;

endmodule

// File: tb/tb_axis_spm_scan_gen.sv
// Scoreboard bench for the scan generator: each scan start pushes the
// expected strobe sequence (time, position, direction, indices); the monitor
// pops and compares on every pixel_strobe.
module tb_axis_spm_scan_gen;

    localparam int DW  = 32;
    localparam int CW  = 16;
    localparam int DEC = 16;

    logic                 a_clk    = 1'b0;
    logic                 a_resetn = 1'b0;
    logic                 start    = 1'b0;
    logic                 stop     = 1'b0;
    logic                 pause    = 1'b0;
    logic [CW-1:0]        nx       = '0;
    logic [CW-1:0]        ny       = '0;
    logic [DEC-1:0]       dwell    = '0;
    logic signed [DW-1:0] x_start  = '0;
    logic signed [DW-1:0] y_start  = '0;
    logic signed [DW-1:0] dx       = '0;
    logic signed [DW-1:0] dy       = '0;

    logic signed [DW-1:0] xs_tdata, ys_tdata;
    logic                 xs_tvalid, ys_tvalid;
    logic                 pixel_strobe, dir, busy, done;
    logic [CW-1:0]        point_cnt, line_cnt;

    axis_spm_scan_gen #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .DECI_WIDTH(DEC)) dut (
        .a_clk            (a_clk),
        .a_resetn         (a_resetn),
        .start            (start),
        .stop             (stop),
        .pause            (pause),
        .nx               (nx),
        .ny               (ny),
        .dwell            (dwell),
        .x_start          (x_start),
        .y_start          (y_start),
        .dx               (dx),
        .dy               (dy),
        .M_AXIS_Xs_tdata  (xs_tdata),
        .M_AXIS_Xs_tvalid (xs_tvalid),
        .M_AXIS_Ys_tdata  (ys_tdata),
        .M_AXIS_Ys_tvalid (ys_tvalid),
        .pixel_strobe     (pixel_strobe),
        .dir              (dir),
        .point_cnt        (point_cnt),
        .line_cnt         (line_cnt),
        .busy             (busy),
        .done             (done)
    );

    always #5 a_clk = ~a_clk;

    longint cyc = 0;
    always @(posedge a_clk) cyc <= cyc + 1;

    typedef struct {
        longint t;
        longint x;
        longint y;
        int     d;
        int     p;
        int     l;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   n_strobes = 0;
    int   done_cnt  = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483647) return -64'sd2147483647;
        return v;
    endfunction

    // Reference frame model: pushes up to max_k strobes; strobes with
    // ordinal >= pause_k are delayed by pause_len cycles.
    task automatic push_frame(input longint t0, input int nx_i, input int ny_i, input int dw_i,
                              input longint xs, input longint ys, input longint dxv, input longint dyv,
                              input int pause_k, input int pause_len, input int max_k,
                              output longint done_t);
        int     n  = (nx_i == 0) ? 1 : nx_i;
        int     nl = (ny_i == 0) ? 1 : ny_i;
        int     d  = (dw_i == 0) ? 1 : dw_i;
        int     k  = 0;
        longint x, y, ls;
        exp_t   it;
        y = ys;
        for (int l = 0; l < nl; l++) begin
            ls = t0 + 2 + longint'(l) * (2 * n + 1) * d;
            x  = xs;
            for (int j = 0; j < 2 * n; j++) begin
                if (j > 0 && j < n) x = sat(x + dxv);
                if (j > n)          x = sat(x - dxv);
                it.t = ls + longint'(j + 1) * d - 1 + ((k >= pause_k) ? pause_len : 0);
                it.x = x;
                it.y = y;
                it.d = (j < n) ? 0 : 1;
                it.p = (j < n) ? j : (2 * n - 1 - j);
                it.l = l;
                if (k < max_k) sb.push_back(it);
                k++;
            end
            y = sat(y + dyv);
        end
        done_t = t0 + 2 + longint'(nl - 1) * (2 * n + 1) * d + longint'(2 * n) * d + pause_len;
    endtask

    // Monitor: one line per strobe, compared against the scoreboard head.
    always @(negedge a_clk) begin
        if (a_resetn && pixel_strobe) begin
            n_strobes++;
            if (sb.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                $display("strobe t=%0d xs=%0d ys=%0d dir=%0d pnt=%0d line=%0d",
                         cyc, xs_tdata, ys_tdata, dir, point_cnt, line_cnt);
                check("strobe_cyc", cyc, e.t);
                check("strobe_xs", xs_tdata, e.x);
                check("strobe_ys", ys_tdata, e.y);
                check("strobe_dir", dir, e.d);
                check("strobe_point", point_cnt, e.p);
                check("strobe_line", line_cnt, e.l);
                check("strobe_tvalid", xs_tvalid & ys_tvalid, 1);
            end
        end
        if (a_resetn && done) done_cnt++;
    end

    task automatic set_cfg(input int nx_i, input int ny_i, input int dw_i,
                           input longint xs, input longint ys, input longint dxv, input longint dyv);
        nx      = CW'(nx_i);
        ny      = CW'(ny_i);
        dwell   = DEC'(dw_i);
        x_start = DW'(xs);
        y_start = DW'(ys);
        dx      = DW'(dxv);
        dy      = DW'(dyv);
    endtask

    task automatic start_scan(output longint t0);
        @(negedge a_clk);
        start = 1'b1;
        t0    = cyc;
        @(negedge a_clk);
        start = 1'b0;
        $display("start t0=%0d nx=%0d ny=%0d dwell=%0d x0=%0d dx=%0d dy=%0d",
                 t0, nx, ny, dwell, x_start, dx, dy);
    endtask

    task automatic wait_done(input string tag, input int budget, input longint exp_t);
        int k = 0;
        do begin
            @(negedge a_clk);
            k++;
        end while (!done && k < budget);
        if (!done) check({tag, "_done_timeout"}, 0, 1);
        else       check({tag, "_done_cyc"}, cyc, exp_t);
    endtask

    task automatic wait_cyc(input longint target);
        while (cyc < target) @(negedge a_clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_xs"}, xs_tdata, 0);
        check({tag, "_ys"}, ys_tdata, 0);
        check({tag, "_tvalid"}, {xs_tvalid, ys_tvalid}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_strobe"}, pixel_strobe, 0);
        check({tag, "_dir"}, dir, 0);
        check({tag, "_cnts"}, {point_cnt, line_cnt}, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        longint t0, dt;
        int     s0, d0;

        // Reset state.
        repeat (3) @(negedge a_clk);
        check_zero("reset");
        a_resetn = 1'b1;
        @(negedge a_clk);
        check("reset_release_busy", busy, 0);

        // Basic frame.
        set_cfg(4, 2, 2, 0, 0, 10, -5);
        s0 = n_strobes;
        start_scan(t0);
        push_frame(t0, 4, 2, 2, 0, 0, 10, -5, 1 << 30, 0, 1 << 30, dt);
        wait_done("basic", 200, dt);
        @(negedge a_clk);
        check("basic_strobes", n_strobes - s0, 16);
        check("basic_busy_after", busy, 0);
        check("basic_sb_empty", sb.size(), 0);
        check("basic_tvalid_held", xs_tvalid, 1);
        check("basic_xs_held", xs_tdata, 0);
        check("basic_ys_held", ys_tdata, -5);

        // Saturation near the positive limit.
        set_cfg(5, 1, 1, 2147483628, 0, 8, 0);
        s0 = n_strobes;
        start_scan(t0);
        push_frame(t0, 5, 1, 1, 2147483628, 0, 8, 0, 1 << 30, 0, 1 << 30, dt);
        wait_done("sat", 100, dt);
        @(negedge a_clk);
        check("sat_strobes", n_strobes - s0, 10);
        check("sat_sb_empty", sb.size(), 0);

        // Pause for 7 cycles in the middle of point 2's dwell.
        set_cfg(4, 1, 4, 0, 0, 10, 0);
        s0 = n_strobes;
        start_scan(t0);
        push_frame(t0, 4, 1, 4, 0, 0, 10, 0, 2, 7, 1 << 30, dt);
        wait_cyc(t0 + 11);
        pause = 1'b1;
        repeat (7) begin
            @(negedge a_clk);
            check("pause_xs_frozen", xs_tdata, 20);
            check("pause_point_frozen", point_cnt, 2);
            check("pause_no_strobe", pixel_strobe, 0);
        end
        pause = 1'b0;
        wait_done("pause", 200, dt);
        @(negedge a_clk);
        check("pause_strobes", n_strobes - s0, 8);
        check("pause_sb_empty", sb.size(), 0);

        // Abort during the return of line 0, then restart.
        set_cfg(4, 2, 2, 0, 0, 10, -5);
        s0 = n_strobes;
        d0 = done_cnt;
        start_scan(t0);
        push_frame(t0, 4, 2, 2, 0, 0, 10, -5, 1 << 30, 0, 5, dt);
        wait_cyc(t0 + 12);
        stop = 1'b1;
        @(negedge a_clk);
        stop = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_xs_held", xs_tdata, 20);
        repeat (3) @(negedge a_clk);
        check("abort_still_idle", busy, 0);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_strobes", n_strobes - s0, 5);
        check("abort_sb_empty", sb.size(), 0);
        start_scan(t0);
        push_frame(t0, 4, 2, 2, 0, 0, 10, -5, 1 << 30, 0, 1 << 30, dt);
        wait_done("restart", 200, dt);
        @(negedge a_clk);
        check("restart_sb_empty", sb.size(), 0);

        // Degenerate counts all treated as 1.
        set_cfg(0, 0, 0, 5, 7, 100, 100);
        s0 = n_strobes;
        start_scan(t0);
        push_frame(t0, 0, 0, 0, 5, 7, 100, 100, 1 << 30, 0, 1 << 30, dt);
        wait_done("degen", 50, dt);
        @(negedge a_clk);
        check("degen_strobes", n_strobes - s0, 2);
        check("degen_busy_after", busy, 0);
        check("degen_sb_empty", sb.size(), 0);

        // Reset during the forward pass of line 1.
        set_cfg(4, 2, 2, 0, 0, 10, -5);
        s0 = n_strobes;
        start_scan(t0);
        push_frame(t0, 4, 2, 2, 0, 0, 10, -5, 1 << 30, 0, 9, dt);
        wait_cyc(t0 + 22);
        check("midrst_line_before", line_cnt, 1);
        a_resetn = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge a_clk);
        start = 1'b1;
        @(negedge a_clk);
        start = 1'b0;
        check_zero("midrst_hold");
        a_resetn = 1'b1;
        @(negedge a_clk);
        check("midrst_start_ignored", busy, 0);
        check("midrst_tvalid", xs_tvalid, 0);
        check("midrst_strobes", n_strobes - s0, 9);
        check("midrst_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
